// File: rtl/brew_sequencer.sv
// Timed recipe sequencer: latches the drink type, heats, runs the ingredient valves in a fixed order, settles, then signals done.
// Define BREW_SEQ_HEAT_TIMEOUT_EN to fault out of HEAT after HEAT_TIMEOUT_UNITS units without heat_ok.
module brew_sequencer #(
  parameter int TICK_DIV           = 50_000_000,
  parameter int DRIP_UNITS         = 2,
  parameter int HEAT_TIMEOUT_UNITS = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] c_type,
  input  logic       heat_ok,
  input  logic       cancel,
  output logic [4:0] valves,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEAT     = 3'd1,
    DISPENSE = 3'd2,
    DRIP     = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int UW = 8;

  state_t        st_q, st_d;
  logic [2:0]    type_q, type_d;
  logic [1:0]    step_q, step_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [UW-1:0] units_q, units_d, lim;
  logic          tick, last_tick;
  logic [4:0]    valves_d;
  logic          aborted_d;
  logic [2:0]    nxt;

  // One nibble per step, coffee in the low nibble up to chocolate in the high one.
  function automatic logic [UW-1:0] recipe(input logic [2:0] t, input logic [1:0] s);
    logic [15:0] row;
    case (t)
      3'd1:    row = 16'h0004;
      3'd2:    row = 16'h0033;
      3'd3:    row = 16'h0322;
      3'd4:    row = 16'h2023;
      default: row = 16'h0000;
    endcase
    return UW'(row[s*4 +: 4]);
  endfunction

  // First non-zero step at or after 'from'; bit 2 set means none left.
  function automatic logic [2:0] find_step(input logic [2:0] t, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--)
      if ((3'(i) >= from) && (recipe(t, 2'(i)) != '0)) r = {1'b0, 2'(i)};
    return r;
  endfunction

  always_comb begin
    case (st_q)
      HEAT:     lim = UW'(HEAT_TIMEOUT_UNITS);
      DISPENSE: lim = recipe(type_q, step_q);
      DRIP:     lim = UW'(DRIP_UNITS);
      default:  lim = '0;
    endcase
  end

  assign tick      = (cnt_q == TW'(TICK_DIV - 1));
  assign last_tick = tick && (units_q == lim - 1'b1);

  always_comb begin
    st_d      = st_q;
    type_d    = type_q;
    step_d    = step_q;
    aborted_d = 1'b0;
    nxt       = '0;
    case (st_q)
      IDLE: begin
        if (start && !cancel && (c_type >= 3'd1) && (c_type <= 3'd4)) begin
          type_d = c_type;
          st_d   = HEAT;
        end
      end
      HEAT: begin
        if (cancel) begin
          st_d      = IDLE;
          aborted_d = 1'b1;
        end else if (heat_ok) begin
          nxt    = find_step(type_q, 3'd0);
          step_d = nxt[1:0];
          st_d   = DISPENSE;
        end
`ifdef BREW_SEQ_HEAT_TIMEOUT_EN
        else if (last_tick) begin
          st_d = FAULT;
        end
`endif
      end
      DISPENSE: begin
        if (cancel) begin
          st_d      = IDLE;
          aborted_d = 1'b1;
        end else if (last_tick) begin
          nxt = find_step(type_q, {1'b0, step_q} + 3'd1);
          if (nxt[2]) st_d = DRIP;
          else        step_d = nxt[1:0];
        end
      end
      DRIP: begin
        if (cancel) begin
          st_d      = IDLE;
          aborted_d = 1'b1;
        end else if (last_tick) begin
          st_d = DONE;
        end
      end
      DONE:  st_d = IDLE;
      FAULT: if (cancel) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Every state or step change restarts the unit timer from a clean zero.
  always_comb begin
    if ((st_d != st_q) || (step_d != step_q)) begin
      cnt_d   = '0;
      units_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      units_d = units_q + 1'b1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      units_d = units_q;
    end
  end

  always_comb begin
    valves_d = '0;
    case (st_d)
      HEAT:     valves_d = 5'b00001;
      DISPENSE: valves_d = (5'b00010 << step_d) | {4'b0000, step_d == 2'd0};
      default:  valves_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= IDLE;
      type_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      units_q <= '0;
      valves  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      st_q    <= st_d;
      type_q  <= type_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      valves  <= valves_d;
      busy    <= (st_d != IDLE);
      done    <= (st_d == DONE);
      aborted <= aborted_d;
    end
  end

  assign state = st_q;

`ifdef BREW_SEQ_HEAT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault <= 1'b0;
    else          fault <= (st_d == FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_brew_sequencer.sv
// Randomized self-checking bench for brew_sequencer against a per-transaction expected-trace model.
module tb_brew_sequencer;

  localparam int T    = 4;
  localparam int DRIP = 2;
  localparam int HTO  = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] c_type;
  logic       heat_ok;
  logic       cancel;
  logic [4:0] valves;
  logic       busy, done, aborted, fault;
  logic [2:0] state;
  logic [11:0] obs;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned rec [4][4] = '{'{4, 0, 0, 0}, '{3, 3, 0, 0}, '{2, 2, 3, 0}, '{3, 2, 0, 2}};

  brew_sequencer #(.TICK_DIV(T), .DRIP_UNITS(DRIP), .HEAT_TIMEOUT_UNITS(HTO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .c_type(c_type), .heat_ok(heat_ok),
    .cancel(cancel), .valves(valves), .busy(busy), .done(done), .aborted(aborted),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, valves, busy, done, aborted, fault};

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ev(input int st, input logic [4:0] v, input logic dn,
                                     input logic ab, input logic ft);
    return {3'(st), v, (st != 0), dn, ab, ft};
  endfunction

  // Expected output trace, one entry per cycle after the start edge.
  task automatic run_brew(input int t, input int h, input bit pre, input int c, input int rs,
                          input string tag);
    logic [11:0] tr[$];
    int          r;
    r = rs;
    for (int i = 0; i < h; i++) tr.push_back(ev(1, 5'b00001, 1'b0, 1'b0, 1'b0));
    for (int s = 0; s < 4; s++) begin
      logic [4:0] v;
      v = 5'(1 << (s + 1)) | ((s == 0) ? 5'b00001 : 5'b00000);
      for (int j = 0; j < int'(rec[t-1][s]) * T; j++) tr.push_back(ev(2, v, 1'b0, 1'b0, 1'b0));
    end
    for (int j = 0; j < DRIP * T; j++) tr.push_back(ev(3, 5'b00000, 1'b0, 1'b0, 1'b0));
    tr.push_back(ev(4, 5'b00000, 1'b1, 1'b0, 1'b0));
    tr.push_back(ev(0, 5'b00000, 1'b0, 1'b0, 1'b0));
    tr.push_back(ev(0, 5'b00000, 1'b0, 1'b0, 1'b0));
    if (c >= 1 && c < tr.size() && tr[c-1][11:9] inside {3'd1, 3'd2, 3'd3}) begin
      while (tr.size() > c) void'(tr.pop_back());
      tr.push_back(ev(0, 5'b00000, 1'b0, 1'b1, 1'b0));
      tr.push_back(ev(0, 5'b00000, 1'b0, 1'b0, 1'b0));
      tr.push_back(ev(0, 5'b00000, 1'b0, 1'b0, 1'b0));
    end
    if (r >= 0 && (r >= tr.size() || tr[r][11:9] == 3'd0)) r = -1;

    heat_ok = pre;
    cancel  = 1'b0;
    c_type  = 3'(t);
    start   = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("%s@0", tag), obs, tr[0]);
    for (int i = 0; i < tr.size() - 1; i++) begin
      heat_ok = pre || (i >= h - 1);
      cancel  = (i == c - 1);
      start   = (i == r);
      c_type  = (i == r) ? 3'd1 : 3'(t);
      step();
      chk($sformatf("%s@%0d", tag, i + 1), obs, tr[i + 1]);
    end
    start   = 1'b0;
    cancel  = 1'b0;
    heat_ok = 1'b0;
  endtask

  task automatic idle_poke(input logic [2:0] ct, input bit cc, input string tag);
    c_type = ct;
    cancel = cc;
    start  = 1'b1;
    step();
    start  = 1'b0;
    cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk(tag, obs, 12'h000);
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    c_type  = 3'd0;
    heat_ok = 1'b0;
    cancel  = 1'b0;
    step();
    step();
    chk("reset", obs, 12'h000);
    reset_n = 1'b1;
    step();
    chk("idle_after_reset", obs, 12'h000);

    run_brew(1, 3, 1'b0, 0, -1, "coffee");
    run_brew(3, 1, 1'b1, 0, -1, "cappuccino");
    run_brew(2, 2, 1'b0, 20, -1, "cancel_milk");

    idle_poke(3'd0, 1'b0, "ctype0");
    idle_poke(3'd7, 1'b0, "ctype7");
    idle_poke(3'd2, 1'b1, "start_cancel");

    // Reset in the middle of the coffee step.
    heat_ok = 1'b1;
    c_type  = 3'd1;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("pre_reset", obs, ev(2, 5'b00011, 1'b0, 1'b0, 1'b0));
    #2 reset_n = 1'b0;
    #1 chk("async_reset", obs, 12'h000);
    step();
    heat_ok = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_reset", obs, 12'h000);

    run_brew(4, 3, 1'b0, 0, 5, "mocca");

    for (int n = 0; n < 12; n++) begin
      int t, h, c, rs;
      bit pre;
      t   = $urandom_range(1, 4);
      pre = ($urandom_range(0, 3) == 0);
      h   = pre ? 1 : $urandom_range(1, 12);
      c   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      rs  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1;
      run_brew(t, h, pre, c, rs, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 3)) step();
    end

    // Heat never arrives.
    heat_ok = 1'b0;
    c_type  = 3'd2;
    start   = 1'b1;
    step();
    start = 1'b0;
`ifdef BREW_SEQ_HEAT_TIMEOUT_EN
    repeat (31) step();
    chk("heat_last", obs, ev(1, 5'b00001, 1'b0, 1'b0, 1'b0));
    step();
    chk("heat_fault", obs, ev(5, 5'b00000, 1'b0, 1'b0, 1'b1));
    repeat (5) step();
    chk("fault_hold", obs, ev(5, 5'b00000, 1'b0, 1'b0, 1'b1));
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("fault_exit", obs, 12'h000);
`else
    repeat (200) step();
    chk("heat_wait", obs, ev(1, 5'b00001, 1'b0, 1'b0, 1'b0));
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("heat_cancel", obs, ev(0, 5'b00000, 1'b0, 1'b1, 1'b0));
`endif
    step();
    chk("final_idle", obs, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
